// File: rtl/rr_arbiter_scan.sv
// Parametrised fixed-priority / round-robin arbiter with a bounded hold (tenure) limit.
// Optional full-scan chain through every state flop, enabled by defining ARB_SCAN_EN.
module rr_arbiter_scan #(
  parameter int NREQ     = 4,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 4,
  parameter int IDXW     = $clog2(NREQ),
  parameter int CNTW     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] request,
  output logic [NREQ-1:0] grant_o,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  input  logic            test_si,
  input  logic            test_se,
  output logic            test_so
);

  localparam int CHAINW = NREQ + IDXW + CNTW;
  localparam logic [CNTW-1:0] HOLD_LIMIT = CNTW'(MAX_HOLD - 1);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NREQ - 1);

  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] grant_n;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_n;
  logic [CNTW-1:0] hold_cnt;
  logic [CNTW-1:0] hold_n;
  logic [NREQ-1:0] cand;
  logic [IDXW-1:0] win;
  logic            found;
  logic            owner_req;
  logic            others;
  logic            at_limit;
  logic [CHAINW-1:0] chain;

  assign chain = {hold_cnt, ptr, grant_q};

  // Candidate vector excludes the owner only when its tenure has expired under contention.
  always_comb begin
    owner_req = |(grant_q & request);
    others    = |(request & ~grant_q);
    at_limit  = (hold_cnt == HOLD_LIMIT);
    cand      = owner_req ? (request & ~grant_q) : request;
    found     = 1'b0;
    win       = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (MODE == 0) ? k : ((int'(ptr) + k) % NREQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDXW'(idx);
      end
    end
  end

  always_comb begin
    grant_n = grant_q;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    if (owner_req && !(at_limit && others)) begin
      if (!at_limit) begin
        hold_n = hold_cnt + CNTW'(1);
      end
    end else begin
      grant_n = '0;
      hold_n  = '0;
      if (found) begin
        grant_n[win] = 1'b1;
        if (MODE == 0) begin
          ptr_n = '0;
        end else begin
          ptr_n = (win == LAST_IDX) ? '0 : win + IDXW'(1);
        end
      end
    end
  end

`ifdef ARB_SCAN_EN
  // Scan shift: test_si enters grant_q[0] and leaves from hold_cnt[CNTW-1].
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else if (test_se) begin
      {hold_cnt, ptr, grant_q} <= {chain[CHAINW-2:0], test_si};
    end else begin
      grant_q  <= grant_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  assign test_so = chain[CHAINW-1];
`else
  logic unused_scan;

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      grant_q  <= grant_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  assign unused_scan = test_si ^ test_se ^ chain[CHAINW-1];
  assign test_so     = 1'b0;
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        grant_idx = grant_idx | IDXW'(i);
      end
    end
  end

  assign grant_o     = grant_q;
  assign grant_valid = |grant_q;

endmodule

// File: doc/rr_arbiter_scan.md
Name: rr_arbiter_scan

Overview:
- Parametrised successor to the 4-request ITC99-style arbiter. Arbitrates NREQ request lines onto a registered one-hot grant.
- Selectable fixed-priority or round-robin mode, with a bounded hold (tenure) limit.
- Full-scan chain through every state flop, so TetraMAX patterns and STILDPV testbenches can be generated for any width.

Parameters:
- NREQ, 4, number of requesters (2..32).
- MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin.
- MAX_HOLD, 4, maximum consecutive grant cycles while other requests are pending (≥1).
- IDXW, $clog2(NREQ), derived; width of grant index and round-robin pointer.
- CNTW, max(1,$clog2(MAX_HOLD)), derived; width of hold counter.

Ports:
- clock  in  1  single rising-edge clock
- reset  in  1  synchronous, active-high reset
- request  in  NREQ  request vector; bit i = requester i
- grant_o  out  NREQ  registered one-hot grant, or all-zero
- grant_valid  out  1  OR of grant_o (registered)
- grant_idx  out  IDXW  index of current owner; 0 when grant_valid=0
- test_si  in  1  scan input
- test_se  in  1  scan enable
- test_so  out  1  scan output

Behaviour:
- State flops: grant_q[NREQ], ptr[IDXW], hold_cnt[CNTW]. All outputs derive directly from these flops; no combinational path from request to outputs.
- Reset (sampled at clock edge with reset=1): grant_q=0, ptr=0, hold_cnt=0, so grant_o=0, grant_valid=0, grant_idx=0, test_so=0. Reset overrides test_se.
- Latency: request sampled at edge k; resulting grant visible after edge k (one cycle).
- Per edge, owner o = current grant (if any):
  - Owner keeps grant if request[o]=1 and NOT (hold_cnt==MAX_HOLD-1 and any other request set). Then hold_cnt increments, saturating at MAX_HOLD-1.
  - Expiry: request[o]=1, hold_cnt==MAX_HOLD-1 and other requests pending. Re-arbitrate among request with bit o masked.
  - Release: request[o]=0 or no owner. Re-arbitrate among full request vector in the same edge; no idle cycle between owners.
  - Re-arbitration with winner w: grant_q = onehot(w), hold_cnt=0. If the masked vector is zero, grant_q=0 and hold_cnt=0.
- Winner selection:
  - MODE=0: lowest set index.
  - MODE=1: first set index searching ptr, ptr+1, ... wrapping modulo NREQ. On every new grant to w, ptr = (w+1) mod NREQ; for non-power-of-2 NREQ, wrap from NREQ-1 to 0.
  - In MODE=0, ptr is held at 0.
- MAX_HOLD=1: owner re-arbitrates every cycle when contenders exist (pure RR handoff).
- A single persistent requester keeps its grant indefinitely; hold_cnt saturates.
- Simultaneous release by owner and new request from the same channel: channel is treated as a fresh requester and competes normally.
- Grant is never multi-hot. grant_idx is consistent with grant_o on every cycle.

Optional Feature:
- Macro: ARB_SCAN_EN.
- Defined:
  - When test_se=1 (and reset=0), all state flops form one shift register; functional update is suppressed.
  - Chain order: test_si -> grant_q[0..NREQ-1] -> ptr[0..IDXW-1] -> hold_cnt[0..CNTW-1] -> test_so.
  - test_so is the last flop's Q. Chain length = NREQ+IDXW+CNTW (8 for defaults).
- Undefined:
  - test_se and test_si are ignored; test_so tied to 0.
  - Functional behaviour is identical in both builds.

Test Plan:
- Reset: request=4'b1111, reset=1 for 2 cycles -> grant_o=0, grant_valid=0, grant_idx=0, test_so=0. First grant after release is 4'b0001 one cycle later.
- RR tenure (MODE=1, MAX_HOLD=4): request=4'b1111 held 16 cycles -> grant_o sequence 0001, 0010, 0100, 1000, each held exactly 4 cycles, then repeating.
- Fixed priority (MODE=0): request=4'b0110 -> grant 0010. Drop request[1] -> grant 0100 next cycle with no idle cycle. Raise request[0] while request[2] holds -> 0100 kept until hold expires, then 0001.
- Sole requester: request=4'b1000 for 10 cycles -> grant_o=1000 every cycle, hold_cnt saturated at 3. Then request=0 -> grant_o=0 next cycle.
- Reset mid-tenure: owner 0010 with hold_cnt=2, assert reset 1 cycle -> all state 0. Next arbitration starts from ptr=0.
- Scan (ARB_SCAN_EN, defaults): test_se=1, shift 8'b10110010 LSB-first over 8 cycles -> state loaded as shifted. Shift 8 more cycles -> same bits appear on test_so in order. Functional grant frozen while test_se=1.
